rv_mc_controller: RTL and testbench
===================================

# rv_mc_controller

Multicycle control FSM for the RV32I core: sequences `ALU32bit`, the PC/IR/ALUOut registers and the memory port across FETCH/DECODE/EXECUTE/MEM/WB. Decodes opcode/funct fields and drives the ALU opcode, mux selects and write enables each cycle. Stalls on a memory ready handshake. Latches into a TRAP state on unsupported instructions.

## Interface
- STATE_W, 4, width of the state register and of `state_o`.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0], taken from the IR.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- alu_zero  in  1  ALUFlags[2] from `ALU32bit`.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR and OldPC load enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- imm_src  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100. Combinational from `op`; 000 for any other opcode.
- alu_op  out  4  ADD = 0100, SUB = 0010, CMP = 1010, MOV = 1101.
- reg_write  out  1  register file write enable.
- illegal  out  1  high while in TRAP.
- state_o  out  STATE_W  current state, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, LUI 8, ALUWB 9, BEQ 10, JAL 11, TRAP 15. All other codes return to FETCH on the next edge.
- Outputs are Moore, decoded from state. The only exceptions are the `mem_ready` and `alu_zero` qualifiers listed below.
- Defaults in every state: enables 0, selects 00, alu_op = ADD. Outputs never take x.
- FETCH: adr_src 0, src_a 00, src_b 10, ADD, result_src 10. ir_write = pc_write = mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: src_a 01, src_b 01, ADD; this computes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR if funct3 = 000, else TRAP.
  - 0010011 → EXECI if funct3 = 000, else TRAP.
  - 1100011 → BEQ if funct3 = 000, else TRAP.
  - 1101111 → JAL.
  - 0110111 → LUI.
  - Anything else → TRAP.
- MEMADR: src_a 10, src_b 01, ADD. Go to MEMRD if op[5] = 0, else MEMWR.
- MEMRD: adr_src 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src 01, reg_write 1. Go to FETCH.
- MEMWR: adr_src 1, mem_write held 1 for the whole state. Wait for mem_ready, then go to FETCH.
- EXECR: src_a 10, src_b 00, alu_op = SUB if funct7b5 else ADD. Go to ALUWB.
- EXECI: src_a 10, src_b 01, ADD. Go to ALUWB.
- LUI: src_b 01, MOV. Go to ALUWB.
- ALUWB: result_src 00, reg_write 1. Go to FETCH.
- BEQ: src_a 10, src_b 00, CMP, result_src 00, pc_write = alu_zero. Go to FETCH.
- JAL: src_a 01, src_b 10, ADD, result_src 00, pc_write 1. Go to ALUWB; this writes OldPC+4 to rd.
- TRAP: all enables 0, illegal 1. Held until reset_n is asserted.

## Timing
- Reset (reset_n low, asynchronous): state = FETCH.
  - pc_write, ir_write, mem_write, reg_write are forced 0 while reset_n is low, regardless of mem_ready.
  - illegal = 0, state_o = 0.
- Reset asserted mid-instruction: abandons the instruction immediately, with no partial write after the edge. The first fetch begins on the first rising edge after release.
- Cycle counts with zero wait states (mem_ready always 1):
  - R-type, I-type, LUI, SW, JAL: 4.
  - LW: 5.
  - BEQ: 3.
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay stable across stall cycles.
- mem_write must not pulse: it stays high continuously from MEMWR entry until the edge on which mem_ready is sampled high.
- pc_write in BEQ is combinational from alu_zero in the same cycle. alu_zero is ignored in every other state.

## Test plan
- Reset, then release with mem_ready = 1 and op = 0110011, funct3 = 000, funct7b5 = 1 → states 0, 1, 6, 9, 0. alu_op = 0010 in EXECR; reg_write = 1 only in ALUWB.
- LW (op = 0000011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total. ir_write pulses once. reg_write with result_src 01 asserts once.
- SW (op = 0100011) with mem_ready low for 2 cycles in MEMWR → mem_write held high for 3 consecutive cycles, then FETCH.
- BEQ:
  - alu_zero = 1 → pc_write = 1 and alu_op = 1010 in state 10.
  - alu_zero = 0 → pc_write = 0.
  - Both cases return to FETCH after 3 cycles.
- JAL (op = 1101111) → states 0, 1, 11, 9. pc_write = 1 in JAL. LUI (op = 0110111) → alu_op = 1101 with src_b 01 in state 8.
- op = 1110011, or op = 0110011 with funct3 = 001 → TRAP (state_o = 15, illegal = 1) held for 20 cycles with all enables 0. Asserting reset_n low mid-TRAP → state 0, illegal = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_mc_controller_if.sv
// rtl/rv_mc_controller_if.sv - decode inputs and control outputs of the multicycle controller
interface rv_mc_controller_if #(parameter int STATE_W = 4);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               alu_zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         imm_src;
  logic [3:0]         alu_op;
  logic               reg_write;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    output op, funct3, funct7b5, alu_zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, illegal, state_o
  );

  modport slave (
    input  op, funct3, funct7b5, alu_zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, illegal, state_o
  );
endinterface

// File: rtl/rv_mc_controller.sv
// rtl/rv_mc_controller.sv - multicycle RV32I control FSM (fetch/decode/execute/mem/writeback)
module rv_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  rv_mc_controller_if.slave  bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXECR  = STATE_W'(6),
    S_EXECI  = STATE_W'(7),
    S_LUI    = STATE_W'(8),
    S_ALUWB  = STATE_W'(9),
    S_BEQ    = STATE_W'(10),
    S_JAL    = STATE_W'(11),
    S_TRAP   = STATE_W'(15)
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu_op;
  logic       w_reg_write;
  logic       w_illegal;
  logic [2:0] w_imm_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = ALU_ADD;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch target
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = (bus.funct3 == 3'b000) ? S_EXECR : S_TRAP;
          7'b0010011: w_next = (bus.funct3 == 3'b000) ? S_EXECI : S_TRAP;
          7'b1100011: w_next = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
          7'b1101111: w_next = S_JAL;
          7'b0110111: w_next = S_LUI;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = bus.op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = bus.funct7b5 ? ALU_SUB : ALU_ADD;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = S_ALUWB;
      end
      S_LUI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = ALU_MOV;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = ALU_CMP;
        w_pc_write  = bus.alu_zero;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target while ALUWB later writes OldPC+4 to rd
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_imm_src = 3'b000;
    case (bus.op)
      7'b0100011: w_imm_src = 3'b001;
      7'b1100011: w_imm_src = 3'b010;
      7'b1101111: w_imm_src = 3'b011;
      7'b0110111: w_imm_src = 3'b100;
      default:    w_imm_src = 3'b000;
    endcase
  end

  // Enables are gated so FETCH's mem_ready passthrough cannot fire during reset
  assign bus.pc_write   = w_pc_write & reset_n;
  assign bus.ir_write   = w_ir_write & reset_n;
  assign bus.mem_write  = w_mem_write & reset_n;
  assign bus.reg_write  = w_reg_write & reset_n;
  assign bus.adr_src    = w_adr_src;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.imm_src    = w_imm_src;
  assign bus.illegal    = w_illegal;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_rv_mc_controller.sv
// tb/tb_rv_mc_controller.sv - directed self-checking bench for rv_mc_controller
module tb_rv_mc_controller;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  int   n_ir;
  int   n_wb;
  int   n_mw;

  rv_mc_controller_if #(.STATE_W(4)) bus();

  rv_mc_controller #(.STATE_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic at(input string tag, input int exp_state, input logic mr);
    bus.mem_ready = mr;
    #1;
    check(tag, 32'(bus.state_o), 32'(exp_state));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] enables();
    return {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write};
  endfunction

  int   lw_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
  logic lw_mr[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
  int   sw_st[6]  = '{0, 1, 2, 5, 5, 5};
  logic sw_mr[6]  = '{1, 1, 1, 0, 0, 1};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n       = 1'b0;
    bus.op        = 7'b0110011;
    bus.funct3    = 3'b000;
    bus.funct7b5  = 1'b1;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(bus.state_o), 0);
    check("rst_enables", 32'(enables()), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // R-type SUB
    at("r_fetch", 0, 1);
    check("r_fetch_ir", 32'(bus.ir_write), 1);
    check("r_fetch_pc", 32'(bus.pc_write), 1);
    check("r_fetch_srcb", 32'(bus.alu_src_b), 2);
    check("r_fetch_res", 32'(bus.result_src), 2);
    check("r_imm", 32'(bus.imm_src), 0);
    adv();
    at("r_decode", 1, 1);
    check("r_dec_srca", 32'(bus.alu_src_a), 1);
    check("r_dec_srcb", 32'(bus.alu_src_b), 1);
    check("r_dec_rw", 32'(bus.reg_write), 0);
    adv();
    at("r_exec", 6, 1);
    check("r_exec_op", 32'(bus.alu_op), 32'h2);
    check("r_exec_rw", 32'(bus.reg_write), 0);
    adv();
    at("r_wb", 9, 1);
    check("r_wb_rw", 32'(bus.reg_write), 1);
    check("r_wb_res", 32'(bus.result_src), 0);
    adv();
    check("r_done", 32'(bus.state_o), 0);

    // LW with 2 fetch stalls and 3 read stalls
    bus.op = 7'b0000011;
    n_ir = 0;
    n_wb = 0;
    for (int i = 0; i < 10; i++) begin
      at("lw_state", lw_st[i], lw_mr[i]);
      if (bus.ir_write) n_ir++;
      if (bus.reg_write && bus.result_src == 2'b01) n_wb++;
      if (lw_st[i] == 3) check("lw_adr", 32'(bus.adr_src), 1);
      adv();
    end
    check("lw_done", 32'(bus.state_o), 0);
    check("lw_ir_cnt", 32'(n_ir), 1);
    check("lw_wb_cnt", 32'(n_wb), 1);

    // SW with 2 write stalls
    bus.op = 7'b0100011;
    n_mw = 0;
    for (int i = 0; i < 6; i++) begin
      at("sw_state", sw_st[i], sw_mr[i]);
      check("sw_mw", 32'(bus.mem_write), (sw_st[i] == 5) ? 1 : 0);
      if (bus.mem_write) n_mw++;
      adv();
    end
    check("sw_done", 32'(bus.state_o), 0);
    check("sw_mw_cnt", 32'(n_mw), 3);

    // BEQ taken and not taken
    bus.op = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      bus.alu_zero = z[0];
      at("beq_fetch", 0, 1);
      adv();
      at("beq_decode", 1, 1);
      adv();
      at("beq_state", 10, 1);
      check("beq_pc", 32'(bus.pc_write), 32'(z));
      check("beq_op", 32'(bus.alu_op), 32'hA);
      check("beq_imm", 32'(bus.imm_src), 2);
      adv();
      check("beq_done", 32'(bus.state_o), 0);
    end
    bus.alu_zero = 1'b0;

    // JAL
    bus.op = 7'b1101111;
    at("jal_fetch", 0, 1);
    adv();
    at("jal_decode", 1, 1);
    adv();
    at("jal_state", 11, 1);
    check("jal_pc", 32'(bus.pc_write), 1);
    check("jal_imm", 32'(bus.imm_src), 3);
    adv();
    at("jal_wb", 9, 1);
    check("jal_wb_rw", 32'(bus.reg_write), 1);
    adv();

    // LUI
    bus.op = 7'b0110111;
    at("lui_fetch", 0, 1);
    adv();
    at("lui_decode", 1, 1);
    adv();
    at("lui_state", 8, 1);
    check("lui_op", 32'(bus.alu_op), 32'hD);
    check("lui_srcb", 32'(bus.alu_src_b), 1);
    check("lui_imm", 32'(bus.imm_src), 4);
    adv();
    at("lui_wb", 9, 1);
    adv();

    // I-type ADDI
    bus.op = 7'b0010011;
    at("i_fetch", 0, 1);
    adv();
    at("i_decode", 1, 1);
    adv();
    at("i_exec", 7, 1);
    check("i_srca", 32'(bus.alu_src_a), 2);
    check("i_op", 32'(bus.alu_op), 32'h4);
    adv();
    at("i_wb", 9, 1);
    adv();

    // Unsupported opcode traps and holds
    bus.op = 7'b1110011;
    at("t1_fetch", 0, 1);
    adv();
    at("t1_decode", 1, 1);
    adv();
    for (int i = 0; i < 20; i++) begin
      at("trap_state", 15, 1);
      check("trap_illegal", 32'(bus.illegal), 1);
      check("trap_enables", 32'(enables()), 0);
      adv();
    end
    #3;
    reset_n = 1'b0;
    #1;
    check("trap_rst_state", 32'(bus.state_o), 0);
    check("trap_rst_illegal", 32'(bus.illegal), 0);
    check("trap_rst_enables", 32'(enables()), 0);
    adv();
    reset_n = 1'b1;

    // R-type with funct3 != 000 traps
    bus.op     = 7'b0110011;
    bus.funct3 = 3'b001;
    at("t2_fetch", 0, 1);
    adv();
    at("t2_decode", 1, 1);
    adv();
    at("t2_trap", 15, 1);
    check("t2_illegal", 32'(bus.illegal), 1);
    adv();
    at("t2_hold", 15, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
